pla_sop_eval_pipe: RTL and testbench
====================================

Name: pla_sop_eval_pipe

Overview:
- Parametrised, pipelined sum-of-products evaluator.
- Generalises our fixed 14-input/1-output benchmark logic to N_IN inputs, N_OUT outputs and N_CUBES run-time-programmable cubes.
- Streams input vectors under valid/ready and also reports a per-vector matching-cube count.
- Sits between a vector source (test pattern generator or host) and a result checker in the benchmark harness.

Parameters:
- N_IN, 14, number of primary inputs.
- N_OUT, 1, number of outputs.
- N_CUBES, 16, cube table depth (power of 2, ≥2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cfg_we  in  1  cube table write strobe.
- cfg_addr  in  $clog2(N_CUBES)  cube index.
- cfg_wdata  in  2*N_IN+N_OUT+1  {valid, care[N_IN], val[N_IN], omask[N_OUT]}.
- cfg_commit  in  1  leave CFG and start evaluating.
- cfg_unlock  in  1  request return to CFG.
- cfg_state  out  2  00 CFG, 01 RUN, 10 DRAIN.
- in_valid  in  1  input vector valid.
- in_ready  out  1  input accepted when high with in_valid.
- in_x  in  N_IN  input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_y  out  N_OUT  function outputs.
- out_hits  out  $clog2(N_CUBES+1)  count of matching valid cubes.

Behaviour:
- Reset (async assert, sync deassert):
  - state=CFG; all cube valid bits=0; both pipeline stages empty.
  - out_valid=0, out_y=0, out_hits=0, in_ready=0.
- Cube match: valid & ((in_x ^ val) & care) == 0. care=0 is a don't-care bit.
- out_y[j] = OR over matching cubes with omask[j]=1.
- out_hits = popcount of all matching cubes, regardless of omask. Width holds N_CUBES with no saturation.
- Pipeline:
  - S1 registers in_x and the per-cube match vector.
  - S2 registers out_y and out_hits.
  - Latency: 2 cycles from input handshake to out_valid with out_ready held at 1.
  - Throughput: 1 vector/cycle.
- Backpressure:
  - A stage advances when its downstream is empty or being consumed.
  - in_ready = (state==RUN) && (S1 empty || S1 advancing). It is combinational from current state and registers, not from in_valid.
  - out_y and out_hits are held stable while out_valid && !out_ready.
  - No vector is dropped or duplicated.
- FSM:
  - CFG: cfg_we writes an entry. cfg_commit → RUN next cycle. cfg_unlock is ignored.
  - RUN: cfg_we and cfg_commit are ignored. cfg_unlock → DRAIN next cycle. A handshake in the same cycle as cfg_unlock is accepted.
  - DRAIN: in_ready=0; cfg_we is ignored. Go to CFG in the cycle after S1 and S2 are both empty, including the final out_ready consumption.
- Simultaneous cfg_we and cfg_commit in CFG: the write lands and is visible to the first RUN vector.
- The table is read only in S1 and only in RUN. CFG writes therefore never affect in-flight vectors.
- Same-address rewrite: the last write wins.
- Cube table is flops; entries other than the valid bit need no reset.
- Reset mid-RUN: in-flight vectors are discarded, out_valid drops immediately, and the table is invalidated.

Decomposition:
- Package pla_sop_pkg holds:
  - the cfg_state encoding localparams;
  - function cube_width(N_IN, N_OUT);
  - field offset localparams for the cfg_wdata packing.
- One sub-module, pla_cube_match: a combinational single-cube matcher, parametrised on N_IN. It is instantiated N_CUBES times via generate.
- Popcount and OR reduction are inline in S2's input logic.

Test Plan:
- Program two cubes, then evaluate 4 vectors with out_ready=1:
  - cube0: care=14'h3F01, val=14'h0001, omask=1, valid.
  - cube1: care=14'h0030, val=14'h0030, omask=0, valid.
  - x=14'h0001 → y=1, hits=1.
  - x=14'h0031 → y=1, hits=2.
  - x=14'h0100 → y=0, hits=0.
  - x=14'h0030 → y=0, hits=1.
  - Each out_valid appears exactly 2 cycles after its handshake.
- Backpressure:
  - Stream 6 vectors with out_ready toggling 1,0,0,1.
  - Results arrive in order, none lost, and outputs stay stable during stalls.
  - in_ready drops when both stages are full.
- Drain:
  - Assert cfg_unlock with 2 vectors in flight and out_ready=0 for 3 cycles.
  - cfg_state=DRAIN; in_ready=0.
  - Both results are delivered, then cfg_state=CFG.
- Config-in-wrong-state writes:
  - A cfg_we in RUN or DRAIN changes nothing: rerunning the same vectors gives identical results.
  - cfg_we together with cfg_commit: the first vector uses the new entry.
- Empty table: commit with no writes → every vector gives y=0, hits=0.
- Async reset during a stalled stream: out_valid=0 and in_ready=0 immediately. After release, cfg_state=CFG and the old cubes no longer match.

Source files
------------

// File: rtl/pla_sop_pkg.sv
// Shared encodings and cfg_wdata field layout for the pipelined SOP evaluator.
// Cube word layout, MSB first: {valid, care[N_IN], val[N_IN], omask[N_OUT]}.
package pla_sop_pkg;

  localparam logic [1:0] StCfg   = 2'b00;
  localparam logic [1:0] StRun   = 2'b01;
  localparam logic [1:0] StDrain = 2'b10;

  localparam int unsigned OmaskLsb = 0;

  function automatic int unsigned cube_width(input int unsigned n_in, input int unsigned n_out);
    return 2 * n_in + n_out + 1;
  endfunction

  function automatic int unsigned val_lsb(input int unsigned n_out);
    return n_out;
  endfunction

  function automatic int unsigned care_lsb(input int unsigned n_in, input int unsigned n_out);
    return n_out + n_in;
  endfunction

  function automatic int unsigned valid_pos(input int unsigned n_in, input int unsigned n_out);
    return 2 * n_in + n_out;
  endfunction

endpackage

// File: rtl/pla_cube_match.sv
// Combinational single-cube matcher; a cleared care bit is a don't-care.
module pla_cube_match #(
  parameter int unsigned N_IN = 14
) (
  input  logic [N_IN-1:0] x,
  input  logic [N_IN-1:0] care,
  input  logic [N_IN-1:0] val,
  input  logic            valid,
  output logic            match
);

  assign match = valid && (((x ^ val) & care) == '0);

endmodule

// File: rtl/pla_sop_eval_pipe.sv
// Two-stage sum-of-products evaluator with a run-time programmable cube table
// and a CFG/RUN/DRAIN controller that keeps table writes away from live vectors.
module pla_sop_eval_pipe
  import pla_sop_pkg::*;
#(
  parameter int unsigned N_IN    = 14,
  parameter int unsigned N_OUT   = 1,
  parameter int unsigned N_CUBES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(N_CUBES)-1:0]   cfg_addr,
  input  logic [2*N_IN+N_OUT:0]        cfg_wdata,
  input  logic                         cfg_commit,
  input  logic                         cfg_unlock,
  output logic [1:0]                   cfg_state,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN-1:0]              in_x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OUT-1:0]             out_y,
  output logic [$clog2(N_CUBES+1)-1:0] out_hits
);

  localparam int unsigned HitsW    = $clog2(N_CUBES + 1);
  localparam int unsigned CubeW    = cube_width(N_IN, N_OUT);
  localparam int unsigned ValLsb   = val_lsb(N_OUT);
  localparam int unsigned CareLsb  = care_lsb(N_IN, N_OUT);
  localparam int unsigned ValidPos = valid_pos(N_IN, N_OUT);

  logic [1:0] state_q, state_d;

  logic [N_CUBES-1:0] tv_q;
  logic [N_IN-1:0]    tcare_q [N_CUBES];
  logic [N_IN-1:0]    tval_q  [N_CUBES];
  logic [N_OUT-1:0]   tomask_q[N_CUBES];

  logic               s1_valid_q;
  logic [N_IN-1:0]    s1_x_q;
  logic [N_CUBES-1:0] s1_match_q;
  logic               s2_valid_q;

  logic [N_CUBES-1:0] match;
  logic [N_OUT-1:0]   y_d;
  logic [HitsW-1:0]   hits_d;
  logic               cfg_wr, s2_ready, s1_adv, in_fire;

  assign cfg_wr   = (state_q == StCfg) && cfg_we;
  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign in_ready = (state_q == StRun) && (!s1_valid_q || s2_ready);
  assign in_fire  = in_valid && in_ready;

  assign cfg_state = state_q;
  assign out_valid = s2_valid_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StCfg:   if (cfg_commit) state_d = StRun;
      StRun:   if (cfg_unlock) state_d = StDrain;
      // Leave once the pipeline is empty after this edge, final consumption included.
      StDrain: if (!s1_valid_q && (!s2_valid_q || out_ready)) state_d = StCfg;
      default: state_d = StCfg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StCfg;
      tv_q    <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_wr) tv_q[cfg_addr] <= cfg_wdata[ValidPos];
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      tcare_q[cfg_addr]  <= cfg_wdata[CareLsb +: N_IN];
      tval_q[cfg_addr]   <= cfg_wdata[ValLsb +: N_IN];
      tomask_q[cfg_addr] <= cfg_wdata[OmaskLsb +: N_OUT];
    end
  end

  for (genvar i = 0; i < N_CUBES; i++) begin : g_cube
    pla_cube_match #(
      .N_IN(N_IN)
    ) u_match (
      .x    (in_x),
      .care (tcare_q[i]),
      .val  (tval_q[i]),
      .valid(tv_q[i]),
      .match(match[i])
    );
  end

  // Stage 1: vector and match vector captured on the input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_x_q     <= in_x;
      s1_match_q <= match;
    end
  end

  always_comb begin
    y_d    = '0;
    hits_d = '0;
    for (int unsigned i = 0; i < N_CUBES; i++) begin
      if (s1_match_q[i]) begin
        y_d    = y_d | tomask_q[i];
        hits_d = hits_d + HitsW'(1);
      end
    end
  end

  // Stage 2: results only load on advance, so they hold during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_y      <= '0;
      out_hits   <= '0;
    end else begin
      s2_valid_q <= s1_adv || (s2_valid_q && !out_ready);
      if (s1_adv) begin
        out_y    <= y_d;
        out_hits <= hits_d;
      end
    end
  end

  // A stalled stage-1 entry must never be overwritten.
  a_s1_hold: assert property (@(posedge clk) disable iff (!rst_n)
    s1_valid_q && !s1_adv |=> $stable(s1_x_q) && $stable(s1_match_q));

  if (CubeW != 2 * N_IN + N_OUT + 1) begin : g_bad_width
    $error("cube word width mismatch");
  end

endmodule

// File: tb/tb_pla_sop_eval_pipe.sv
// Directed bench for pla_sop_eval_pipe: hand-computed results checked in order
// through a scoreboard queue, plus FSM, backpressure and reset scenarios.
module tb_pla_sop_eval_pipe;
  import pla_sop_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_commit, cfg_unlock;
  logic [3:0]  cfg_addr;
  logic [29:0] cfg_wdata;
  logic [1:0]  cfg_state;
  logic        in_valid, in_ready;
  logic [13:0] in_x;
  logic        out_valid, out_ready;
  logic [0:0]  out_y;
  logic [4:0]  out_hits;

  always #5 clk = ~clk;

  pla_sop_eval_pipe #(
    .N_IN   (14),
    .N_OUT  (1),
    .N_CUBES(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_commit(cfg_commit),
    .cfg_unlock(cfg_unlock),
    .cfg_state (cfg_state),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_hits  (out_hits)
  );

  typedef struct {
    logic       y;
    logic [4:0] h;
    int         c;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_out = 0;
  int         rk = 0;
  logic [3:0] rdy_pat = 4'hF;
  logic       mon_en = 1'b0, lat_chk = 1'b0, chk_rdy = 1'b0, saw_block = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_y;
  logic [4:0] prev_h;
  logic       cur_y;
  logic [4:0] cur_h;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [29:0] mk(input logic v, input logic [13:0] c, input logic [13:0] vl,
                                     input logic o);
    return {v, c, vl, o};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    out_ready = rdy_pat[rk];
    rk = (rk + 1) % 4;
  end

  // Scoreboard: in_ready model, stall stability, in-order results, latency.
  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_rdy) begin
        check_eq("in_ready_model", in_ready, (exp_q.size() < 2) || out_ready);
        if (in_valid && !in_ready) saw_block = 1'b1;
      end
      if (prev_stall) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_y", out_y, prev_y);
        check_eq("stall_hits", out_hits, prev_h);
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      prev_h     = out_hits;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_y", out_y, e.y);
          check_eq("out_hits", out_hits, e.h);
          if (lat_chk) check_eq("latency", cyc - e.c, 2);
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{cur_y, cur_h, cyc});
    end
  end

  task automatic send(input logic [13:0] x, input logic y, input logic [4:0] h, input logic unl);
    int n;
    n = 0;
    in_x = x; cur_y = y; cur_h = h; in_valid = 1'b1; cfg_unlock = unl;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check_eq("send_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_unlock = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [29:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_unlock = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    #3;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_state", cfg_state, StCfg);
    check_eq("rst_out_y", out_y, 0);
    check_eq("rst_out_hits", out_hits, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1; lat_chk = 1'b1;
    @(posedge clk); #1;

    // Program with a same-address rewrite on cube 1; the later value must win.
    cfg_write(4'd1, mk(1'b1, 14'h0000, 14'h0000, 1'b1));
    cfg_write(4'd0, mk(1'b1, 14'h3F01, 14'h0001, 1'b1));
    cfg_write(4'd1, mk(1'b1, 14'h0030, 14'h0030, 1'b0));
    check_eq("cfg_hold", cfg_state, StCfg);
    check_eq("cfg_in_ready", in_ready, 0);
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    check_eq("commit_state", cfg_state, StRun);
    check_eq("run_in_ready", in_ready, 1);

    send(14'h0001, 1'b1, 5'd1, 1'b0);
    send(14'h0031, 1'b1, 5'd2, 1'b0);
    send(14'h0100, 1'b0, 5'd0, 1'b0);
    send(14'h0030, 1'b0, 5'd1, 1'b0);
    wait_idle("basic_idle");
    lat_chk = 1'b0;

    // Backpressure with out_ready cycling 1,0,0,1.
    rdy_pat = 4'b1001; chk_rdy = 1'b1; saw_block = 1'b0; n_out = 0;
    send(14'h0001, 1'b1, 5'd1, 1'b0);
    send(14'h0031, 1'b1, 5'd2, 1'b0);
    send(14'h0100, 1'b0, 5'd0, 1'b0);
    send(14'h0030, 1'b0, 5'd1, 1'b0);
    send(14'h0001, 1'b1, 5'd1, 1'b0);
    send(14'h0031, 1'b1, 5'd2, 1'b0);
    rdy_pat = 4'hF;
    wait_idle("bp_idle");
    chk_rdy = 1'b0;
    check_eq("bp_saw_block", saw_block, 1);
    check_eq("bp_count", n_out, 6);

    // Writes in RUN must be ignored.
    cfg_write(4'd2, mk(1'b1, 14'h0000, 14'h0000, 1'b1));
    cfg_write(4'd0, mk(1'b0, 14'h0000, 14'h0000, 1'b0));
    send(14'h0100, 1'b0, 5'd0, 1'b0);
    send(14'h0001, 1'b1, 5'd1, 1'b0);
    wait_idle("run_wr_idle");

    // Drain: unlock alongside the second handshake, outputs stalled.
    rdy_pat = 4'h0;
    @(posedge clk); #1;
    send(14'h0001, 1'b1, 5'd1, 1'b0);
    send(14'h0031, 1'b1, 5'd2, 1'b1);
    check_eq("drain_state0", cfg_state, StDrain);
    check_eq("drain_in_ready0", in_ready, 0);
    cfg_write(4'd1, mk(1'b0, 14'h0000, 14'h0000, 1'b0));
    check_eq("drain_state1", cfg_state, StDrain);
    check_eq("drain_in_ready1", in_ready, 0);
    @(posedge clk); #1;
    check_eq("drain_state2", cfg_state, StDrain);
    check_eq("drain_inflight", exp_q.size(), 2);
    rdy_pat = 4'hF;
    for (int i = 0; i < 20 && cfg_state != StCfg; i++) begin
      @(posedge clk); #1;
    end
    check_eq("drain_to_cfg", cfg_state, StCfg);
    check_eq("drain_delivered", exp_q.size(), 0);

    // Write together with commit; earlier RUN/DRAIN writes must not have landed.
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = mk(1'b1, 14'h3FFF, 14'h0100, 1'b1);
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_commit = 1'b0;
    check_eq("commit2_state", cfg_state, StRun);
    lat_chk = 1'b1;
    send(14'h0100, 1'b1, 5'd1, 1'b0);
    send(14'h0031, 1'b1, 5'd2, 1'b0);
    send(14'h0030, 1'b0, 5'd1, 1'b0);
    send(14'h0001, 1'b1, 5'd1, 1'b0);
    wait_idle("rerun_idle");
    lat_chk = 1'b0;

    // Async reset with a stalled stream in flight.
    rdy_pat = 4'h0;
    @(posedge clk); #1;
    send(14'h0001, 1'b1, 5'd1, 1'b0);
    send(14'h0031, 1'b1, 5'd2, 1'b0);
    @(posedge clk); #3;
    check_eq("pre_rst_valid", out_valid, 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_in_ready", in_ready, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("arst_state", cfg_state, StCfg);
    rdy_pat = 4'hF; mon_en = 1'b1;
    @(posedge clk); #1;

    // Empty table after reset: nothing may match.
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    check_eq("empty_state", cfg_state, StRun);
    lat_chk = 1'b1;
    send(14'h0001, 1'b0, 5'd0, 1'b0);
    send(14'h0031, 1'b0, 5'd0, 1'b0);
    send(14'h0030, 1'b0, 5'd0, 1'b0);
    send(14'h0100, 1'b0, 5'd0, 1'b0);
    wait_idle("empty_idle");
    lat_chk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
